// File: rtl/reg_bank_pkg.sv
// Shared encodings for the register bank: B-bus select codes, C-bus write-enable
// bit positions, and a multi-hot detector used for the write-collision flag.
// Contents: SEL_* codes, WE_* bit positions, bsrc_e source class, multi_hot().
package reg_bank_pkg;

    // B-bus select encodings: GPR k is selected by SEL_R0 + k.
    localparam int SEL_PC = 0;
    localparam int SEL_AR = 1;
    localparam int SEL_R0 = 2;

    // C-bus write-enable bit positions: GPR k owns bit WE_R0 + k.
    localparam int WE_PC = 0;
    localparam int WE_AR = 1;
    localparam int WE_R0 = 2;

    // Largest supported bank, used to size the shared multi-hot helper.
    localparam int NREG_MAX = 32;
    localparam int WE_MAX   = NREG_MAX + 2;

    // Class of register a b_sel value resolves to.
    typedef enum logic [1:0] {
        SRC_PC   = 2'd0,
        SRC_AR   = 2'd1,
        SRC_GPR  = 2'd2,
        SRC_NONE = 2'd3
    } bsrc_e;

    // True when more than one bit is set: clearing the lowest set bit
    // leaves something behind only if a second bit was present.
    function automatic logic multi_hot(input logic [WE_MAX-1:0] v);
        logic [WE_MAX-1:0] one;
        one = {{(WE_MAX-1){1'b0}}, 1'b1};
        return (v & (v - one)) != '0;
    endfunction

endpackage

// File: rtl/reg_bank_unit_inc_reg.sv
// Loadable, incrementing register used for PC and each general-purpose register.
// Latency: load/increment visible one clock after the enabling edge; no backpressure.
// Ports: clk, rst_n (async active-low), ld_i, inc_i, d_i -> q_o.
module inc_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic         inc_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // A load wins over an increment in the same cycle; the increment is
    // dropped rather than queued. Addition wraps naturally at W bits.
    always_comb begin
        q_d = q_q;
        if (ld_i) begin
            q_d = d_i;
        end else if (inc_i) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/reg_bank_unit.sv
// Datapath register bank: PC, AR, NREG GPRs and IR, with C-bus writes and a B-bus read mux.
// Latency: writes/increments/IR load take effect at the next clk edge; b_bus is combinational.
// Backpressure: none; every request is accepted each cycle. Multi-hot c_we writes all targets
// and raises we_err for the following cycle.
// Ports: clk, rst_n, c_bus, c_we[NREG+2], pc_inc, r_inc[NREG], iram_data, ld_ir, b_sel ->
//        b_bus, pc_out, ar_out, ir_out, we_err.
module reg_bank_unit
    import reg_bank_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int NREG   = 8,
    parameter  int IR_W   = 6,
    localparam int SEL_W  = $clog2(NREG + 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] c_bus,
    input  logic [NREG+1:0]   c_we,
    input  logic              pc_inc,
    input  logic [NREG-1:0]   r_inc,
    input  logic [IR_W-1:0]   iram_data,
    input  logic              ld_ir,
    input  logic [SEL_W-1:0]  b_sel,
    output logic [DATA_W-1:0] b_bus,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] ar_out,
    output logic [IR_W-1:0]   ir_out,
    output logic              we_err
);

    // ------------------------------------------------------------------
    // Incrementing registers: PC and the general-purpose bank
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] gpr_q [NREG];

    inc_reg #(.W(DATA_W)) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (c_we[WE_PC]),
        .inc_i (pc_inc),
        .d_i   (c_bus),
        .q_o   (pc_q)
    );

    for (genvar k = 0; k < NREG; k++) begin : g_gpr
        inc_reg #(.W(DATA_W)) u_gpr (
            .clk   (clk),
            .rst_n (rst_n),
            .ld_i  (c_we[WE_R0 + k]),
            .inc_i (r_inc[k]),
            .d_i   (c_bus),
            .q_o   (gpr_q[k])
        );
    end

    // ------------------------------------------------------------------
    // Plain loadable registers: AR, IR and the collision flag
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ar_q;
    logic [DATA_W-1:0] ar_d;
    logic [IR_W-1:0]   ir_q;
    logic [IR_W-1:0]   ir_d;
    logic              we_err_q;
    logic              we_err_d;

    always_comb begin
        ar_d     = ar_q;
        ir_d     = ir_q;
        if (c_we[WE_AR]) begin
            ar_d = c_bus;
        end
        // IR is fed from instruction RAM and ignores the C-bus enables.
        if (ld_ir) begin
            ir_d = iram_data;
        end
        // Flag is recomputed every cycle, so a single collision shows for
        // exactly one cycle unless the next cycle also collides.
        we_err_d = multi_hot(WE_MAX'(c_we));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_q     <= '0;
            ir_q     <= '0;
            we_err_q <= 1'b0;
        end else begin
            ar_q     <= ar_d;
            ir_q     <= ir_d;
            we_err_q <= we_err_d;
        end
    end

    // ------------------------------------------------------------------
    // B-bus read mux: no write bypass, so a same-cycle write is only
    // visible after the edge. Unused select codes read as zero.
    // ------------------------------------------------------------------
    bsrc_e                 bsrc;
    logic [DATA_W-1:0]     gpr_rd;

    always_comb begin
        bsrc   = SRC_NONE;
        gpr_rd = '0;
        if (b_sel == SEL_W'(SEL_PC)) begin
            bsrc = SRC_PC;
        end else if (b_sel == SEL_W'(SEL_AR)) begin
            bsrc = SRC_AR;
        end else begin
            for (int k = 0; k < NREG; k++) begin
                if (b_sel == SEL_W'(SEL_R0 + k)) begin
                    bsrc   = SRC_GPR;
                    gpr_rd = gpr_q[k];
                end
            end
        end
    end

    always_comb begin
        b_bus = '0;
        case (bsrc)
            SRC_PC:  b_bus = pc_q;
            SRC_AR:  b_bus = ar_q;
            SRC_GPR: b_bus = gpr_rd;
            default: b_bus = '0;
        endcase
    end

    assign pc_out = pc_q;
    assign ar_out = ar_q;
    assign ir_out = ir_q;
    assign we_err = we_err_q;

endmodule

// File: tb/tb_reg_bank_unit.sv
// Bench for reg_bank_unit: directed boundary cases followed by randomized traffic,
// all outputs compared every falling edge against a behavioural model of the bank.
module tb_reg_bank_unit;

    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int IR_W   = 6;
    localparam int SEL_W  = $clog2(NREG + 2);
    localparam int NWE    = NREG + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] c_bus;
    logic [NWE-1:0]    c_we;
    logic              pc_inc;
    logic [NREG-1:0]   r_inc;
    logic [IR_W-1:0]   iram_data;
    logic              ld_ir;
    logic [SEL_W-1:0]  b_sel;
    logic [DATA_W-1:0] b_bus;
    logic [DATA_W-1:0] pc_out;
    logic [DATA_W-1:0] ar_out;
    logic [IR_W-1:0]   ir_out;
    logic              we_err;

    reg_bank_unit #(.DATA_W(DATA_W), .NREG(NREG), .IR_W(IR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .c_bus     (c_bus),
        .c_we      (c_we),
        .pc_inc    (pc_inc),
        .r_inc     (r_inc),
        .iram_data (iram_data),
        .ld_ir     (ld_ir),
        .b_sel     (b_sel),
        .b_bus     (b_bus),
        .pc_out    (pc_out),
        .ar_out    (ar_out),
        .ir_out    (ir_out),
        .we_err    (we_err)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] m_pc;
    logic [DATA_W-1:0] m_ar;
    logic [DATA_W-1:0] m_r [NREG];
    logic [IR_W-1:0]   m_ir;
    logic              m_err;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pc  = '0;
        m_ar  = '0;
        m_ir  = '0;
        m_err = 1'b0;
        for (int k = 0; k < NREG; k++) m_r[k] = '0;
    endtask

    function automatic logic [DATA_W-1:0] exp_b(input logic [SEL_W-1:0] s);
        int v;
        v = int'(s);
        if (v == 0) return m_pc;
        if (v == 1) return m_ar;
        if (v < NREG + 2) return m_r[v-2];
        return '0;
    endfunction

    always @(negedge rst_n) model_clear();

    // Each register: write if its enable is set, else +1 if asked, else hold.
    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            if (c_we[0]) m_pc = c_bus;
            else if (pc_inc) m_pc = m_pc + 16'd1;
            if (c_we[1]) m_ar = c_bus;
            for (int k = 0; k < NREG; k++) begin
                if (c_we[k+2]) m_r[k] = c_bus;
                else if (r_inc[k]) m_r[k] = m_r[k] + 16'd1;
            end
            if (ld_ir) m_ir = iram_data;
            m_err = ($countones(c_we) > 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_b_bus",  b_bus,  exp_b(b_sel));
            check("cyc_pc",     pc_out, m_pc);
            check("cyc_ar",     ar_out, m_ar);
            check("cyc_ir",     ir_out, m_ir);
            check("cyc_we_err", we_err, m_err);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic idle();
        c_we   = '0;
        pc_inc = 1'b0;
        r_inc  = '0;
        ld_ir  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        c_bus     = '0;
        iram_data = '0;
        b_sel     = '0;
        rst_n     = 1'b0;
        model_clear();
        chk_en    = 1'b1;

        // Reset held while the clock runs
        step();
        check("rst_b_bus", b_bus, 16'h0000);
        check("rst_we_err", we_err, 1'b0);
        #1 rst_n = 1'b1;

        // Select sweep after reset, including unused codes
        step();
        for (int s = 0; s < 16; s++) begin
            b_sel = SEL_W'(s);
            #1;
            check($sformatf("sweep_sel%0d", s), b_bus, 16'h0000);
        end
        check("sweep_we_err", we_err, 1'b0);

        // PC wrap
        step();
        c_we  = NWE'(1);
        c_bus = 16'hFFFE;
        step();
        idle();
        check("pc_load", pc_out, 16'hFFFE);
        pc_inc = 1'b1;
        step();
        check("pc_inc1", pc_out, 16'hFFFF);
        step();
        check("pc_wrap", pc_out, 16'h0000);
        check("model_pc_wrap", m_pc, 16'h0000);
        step();
        check("pc_inc3", pc_out, 16'h0001);
        pc_inc = 1'b0;

        // Write beats increment on R2
        c_we  = NWE'(1) << 4;
        c_bus = 16'h1234;
        r_inc = NREG'(1) << 2;
        step();
        idle();
        b_sel = SEL_W'(4);
        #1;
        check("r2_write_prio", b_bus, 16'h1234);
        check("model_r2", m_r[2], 16'h1234);

        // Multi-hot write: AR and R1
        c_we  = NWE'('b1010);
        c_bus = 16'hA5A5;
        step();
        idle();
        check("multi_ar", ar_out, 16'hA5A5);
        check("multi_err_hi", we_err, 1'b1);
        b_sel = SEL_W'(3);
        #1;
        check("multi_r1", b_bus, 16'hA5A5);
        step();
        check("multi_err_lo", we_err, 1'b0);

        // Read/write same register: no bypass
        c_we  = NWE'(1) << 7;
        c_bus = 16'h1111;
        step();
        c_bus = 16'h00FF;
        b_sel = SEL_W'(7);
        #1;
        check("r5_old", b_bus, 16'h1111);
        step();
        idle();
        check("r5_new", b_bus, 16'h00FF);
        b_sel = SEL_W'(15);
        #1;
        check("sel15_zero", b_bus, 16'h0000);

        // IR load then asynchronous reset mid-cycle with a pending write
        ld_ir     = 1'b1;
        iram_data = 6'h2A;
        step();
        ld_ir = 1'b0;
        check("ir_load", ir_out, 6'h2A);
        c_we  = NWE'(1);
        c_bus = 16'hBEEF;
        b_sel = SEL_W'(0);
        #2 rst_n = 1'b0;
        #1;
        check("async_ir", ir_out, 6'h00);
        check("async_ar", ar_out, 16'h0000);
        check("async_b_bus", b_bus, 16'h0000);
        step();
        step();
        check("rst_abort_pc", pc_out, 16'h0000);
        #1 rst_n = 1'b1;
        step();
        check("first_after_rst", pc_out, 16'hBEEF);
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step();
            if (i == 200) begin
                #2 rst_n = 1'b0;
                step();
                #1 rst_n = 1'b1;
            end
            c_bus = DATA_W'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: c_we = '0;
                4, 5, 6, 7: c_we = NWE'(1) << $urandom_range(0, NWE-1);
                default:    c_we = NWE'($urandom);
            endcase
            pc_inc    = 1'($urandom);
            r_inc     = NREG'($urandom);
            ld_ir     = 1'($urandom);
            iram_data = IR_W'($urandom);
            b_sel     = SEL_W'($urandom);
        end

        step();
        idle();
        step();
        step();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bank_unit.md
REG_BANK_UNIT -- requirements
Module: reg_bank_unit

Interface
REQ-001 Parameter DATA_W, default 16, sets the width of every data register and bus.
REQ-002 Parameter NREG, default 8, sets the number of general-purpose registers R0..R(NREG-1); legal range 2..32.
REQ-003 Parameter IR_W, default 6, sets the instruction register width.
REQ-004 Derived constant SEL_W = clog2(NREG+2) sets the B-bus select width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 c_bus  input  DATA_W  C-bus write data.
REQ-008 c_we  input  NREG+2  one-hot write enables: bit0 PC, bit1 AR, bit k+2 Rk.
REQ-009 pc_inc  input  1  PC increment request.
REQ-010 r_inc  input  NREG  per-GPR increment requests, bit k for Rk.
REQ-011 iram_data  input  IR_W  instruction word from instruction RAM.
REQ-012 ld_ir  input  1  IR load strobe.
REQ-013 b_sel  input  SEL_W  B-bus source select: 0 PC, 1 AR, k+2 Rk.
REQ-014 b_bus  output  DATA_W  selected register value.
REQ-015 pc_out  output  DATA_W  current PC.
REQ-016 ar_out  output  DATA_W  current AR.
REQ-017 ir_out  output  IR_W  current IR.
REQ-018 we_err  output  1  registered flag for a multi-hot c_we.

Function
REQ-019 Load a register with c_bus at a clock edge when its c_we bit is 1.
REQ-020 Add 1 modulo 2^DATA_W to PC when pc_inc=1 and c_we[0]=0; all-ones wraps to 0.
REQ-021 Add 1 modulo 2^DATA_W to Rk when r_inc[k]=1 and c_we[k+2]=0; AR has no increment.
REQ-022 Give a write priority over an increment to the same register in the same cycle; the increment is discarded, not deferred.
REQ-023 Load iram_data into IR when ld_ir=1; IR is independent of c_we.
REQ-024 Drive b_bus combinationally from b_sel, with zero latency.
REQ-025 Drive b_bus to 0 when b_sel > NREG+1.
REQ-026 On a read and write of the same register in one cycle, show the old value on b_bus until the edge and the new value after it; there is no bypass.
REQ-027 When c_we has more than one bit set, write all selected registers with c_bus and assert we_err for exactly the following cycle.
REQ-028 Hold every register whose enable and increment are both 0.

Reset
REQ-029 While rst_n=0, asynchronously clear PC, AR, all Rk, IR and we_err to 0.
REQ-030 Keep b_bus equal to the mux of the cleared registers during reset (0).
REQ-031 A reset asserted mid-operation aborts any pending write or increment, and no partial update survives.
REQ-032 After rst_n is released, accept the first update at the next rising edge.

Structure
REQ-033 Place the b_sel encodings (SEL_PC=0, SEL_AR=1, SEL_R0=2) and the c_we bit positions in shared package reg_bank_pkg.
REQ-034 Implement PC and each Rk as instances of one sub-module inc_reg (load, increment, async reset, width DATA_W).
REQ-035 Implement AR and IR as plain loadable registers inside reg_bank_unit.

Verification
REQ-036 Reset, then b_sel sweeps 0..NREG+1 -> b_bus=0 for every select; we_err=0.
REQ-037 PC written 16'hFFFE, then pc_inc for 3 cycles -> pc_out 16'hFFFF, 16'h0000, 16'h0001.
REQ-038 c_we[4]=1 with c_bus=16'h1234 and r_inc[2]=1 in the same cycle -> R2=16'h1234, not 16'h1235.
REQ-039 c_we=bits 1 and 3 with c_bus=16'hA5A5 -> AR=R1=16'hA5A5; we_err high for exactly one cycle.
REQ-040 Write R5=16'h00FF with b_sel=7 in the same cycle -> b_bus old value before the edge, 16'h00FF after; b_sel=15 -> b_bus=0.
REQ-041 ld_ir with iram_data=6'h2A, then rst_n pulsed low mid-cycle -> ir_out=6'h2A, then 0 immediately on reset without waiting for clk.
